// File: rtl/cmos_pkg.sv
// Shared types and elaboration helpers for the DVP capture path.
// Holds the capture FSM encoding, the BEATS legality check and the beat counter width.
package cmos_pkg;

  typedef enum logic [1:0] {WAIT_VS, SKIP, ACTIVE} cap_state_t;

  localparam int BEATS_MIN = 1;
  localparam int BEATS_MAX = 4;

  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic bit beats_ok(input int beats);
    return (beats >= BEATS_MIN) && (beats <= BEATS_MAX);
  endfunction

endpackage

// File: rtl/cmos_sync_edge.sv
// Registers VSYNC/HREF once and flags frame start, line start and line end.
// Edge flags are combinational from the current input and the 1-cycle delayed copy; no backpressure.
module cmos_sync_edge #(
  parameter int VS_POL = 1
) (
  input  logic pclk,
  input  logic rst,
  input  logic vs_i,
  input  logic de_i,
  output logic frame_start,
  output logic line_start,
  output logic line_end
);

  localparam logic VS_ACT = (VS_POL != 0);

  logic vs_r;
  logic de_r;

  // vs_r resets to the active level so a sync already asserted at reset is not taken as an edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_r <= VS_ACT;
      de_r <= 1'b0;
    end else begin
      vs_r <= vs_i;
      de_r <= de_i;
    end
  end

  assign frame_start = (vs_r != VS_ACT) && (vs_i == VS_ACT);
  assign line_start  = !de_r && de_i;
  assign line_end    = de_r && !de_i;

endmodule

// File: rtl/cmos_pixel_pack.sv
// Packs BEATS sensor samples into one word with frame gating, SOF/EOL markers and partial-line detection.
// 1 cycle from last sample to pix_valid_o; no backpressure, the downstream FIFO must take every strobe.
module cmos_pixel_pack
  import cmos_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int BEATS      = 2,
  parameter int BYTE_ORDER = 0,
  parameter int VS_POL     = 1,
  parameter int FRAME_SKIP = 2
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  output logic                  pix_valid_o,
  output logic [IN_W*BEATS-1:0] pix_data_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  err_partial_o,
  output logic                  frame_active_o
);

  localparam int OUT_W = IN_W * BEATS;
  localparam int BW    = beat_w(BEATS);

  if (!beats_ok(BEATS)) begin : g_bad_beats
    $error("cmos_pixel_pack: BEATS must be in 1..4");
  end

  cap_state_t       state;
  logic [7:0]       skip_cnt;
  logic [7:0]       skip_nxt;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    slot;
  logic             last_beat;
  logic             sof_pending;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] word_next;
  logic             frame_start;
  logic             line_start;
  logic             line_end;

  cmos_sync_edge #(
    .VS_POL(VS_POL)
  ) u_sync_edge (
    .pclk       (pclk),
    .rst        (rst),
    .vs_i       (vs_i),
    .de_i       (de_i),
    .frame_start(frame_start),
    .line_start (line_start),
    .line_end   (line_end)
  );

  // A fresh line always begins a new word in slot 0.
  always_comb begin
    slot      = line_start ? '0 : beat;
    last_beat = (slot == BW'(BEATS - 1));
    skip_nxt  = skip_cnt + 8'd1;
    word_next = acc;
    if (BYTE_ORDER == 0) begin
      word_next[IN_W*(BEATS-1-int'(slot)) +: IN_W] = pdata_i;
    end else begin
      word_next[IN_W*int'(slot) +: IN_W] = pdata_i;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state          <= WAIT_VS;
      skip_cnt       <= 8'd0;
      beat           <= '0;
      sof_pending    <= 1'b1;
      acc            <= '0;
      pix_valid_o    <= 1'b0;
      pix_data_o     <= '0;
      sof_o          <= 1'b0;
      eol_o          <= 1'b0;
      err_partial_o  <= 1'b0;
      frame_active_o <= 1'b0;
    end else begin
      pix_valid_o   <= 1'b0;
      sof_o         <= 1'b0;
      eol_o         <= 1'b0;
      err_partial_o <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (frame_start) begin
            skip_cnt <= 8'd0;
            if (FRAME_SKIP == 0) begin
              state          <= ACTIVE;
              frame_active_o <= 1'b1;
            end else begin
              state <= SKIP;
            end
          end
        end
        SKIP: begin
          if (frame_start) begin
            skip_cnt <= skip_nxt;
            if (skip_nxt == 8'(FRAME_SKIP)) begin
              state          <= ACTIVE;
              frame_active_o <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (de_i) begin
            acc <= word_next;
            if (last_beat) begin
              pix_data_o  <= word_next;
              pix_valid_o <= 1'b1;
              sof_o       <= sof_pending;
              sof_pending <= 1'b0;
              beat        <= '0;
            end else begin
              beat <= slot + 1'b1;
            end
          end else if (line_end) begin
            eol_o         <= 1'b1;
            err_partial_o <= (beat != '0) && !frame_start;
            beat          <= '0;
          end
          // A new frame silently drops any half-built word.
          if (frame_start) begin
            beat <= '0;
          end
        end
        default: state <= WAIT_VS;
      endcase
      if (frame_start) begin
        sof_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Bench for cmos_pixel_pack: three parameter sets share one stimulus stream and
// are checked every cycle against a sample-queue model, plus literal directed checks.
module tb_cmos_pixel_pack;

  localparam int CB[3] = '{2, 3, 1};   // BEATS
  localparam int CO[3] = '{0, 1, 0};   // BYTE_ORDER
  localparam int CP[3] = '{1, 1, 0};   // VS_POL
  localparam int CS[3] = '{0, 2, 1};   // FRAME_SKIP

  logic       pclk = 1'b0;
  logic       rst;
  logic       vs;
  logic       de;
  logic [7:0] pd;

  logic        v0, v1, v2, f0, f1, f2, l0, l1, l2, p0, p1, p2, a0, a1, a2;
  logic [15:0] d0;
  logic [23:0] d1;
  logic [7:0]  d2;

  logic        o_vld[3], o_sof[3], o_eol[3], o_err[3], o_act[3];
  logic [31:0] o_data[3];

  cmos_pixel_pack #(.IN_W(8), .BEATS(2), .BYTE_ORDER(0), .VS_POL(1), .FRAME_SKIP(0)) u0 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pd),
    .pix_valid_o(v0), .pix_data_o(d0), .sof_o(f0), .eol_o(l0),
    .err_partial_o(p0), .frame_active_o(a0));

  cmos_pixel_pack #(.IN_W(8), .BEATS(3), .BYTE_ORDER(1), .VS_POL(1), .FRAME_SKIP(2)) u1 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pd),
    .pix_valid_o(v1), .pix_data_o(d1), .sof_o(f1), .eol_o(l1),
    .err_partial_o(p1), .frame_active_o(a1));

  cmos_pixel_pack #(.IN_W(8), .BEATS(1), .BYTE_ORDER(0), .VS_POL(0), .FRAME_SKIP(1)) u2 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pd),
    .pix_valid_o(v2), .pix_data_o(d2), .sof_o(f2), .eol_o(l2),
    .err_partial_o(p2), .frame_active_o(a2));

  assign o_vld[0] = v0;  assign o_vld[1] = v1;  assign o_vld[2] = v2;
  assign o_sof[0] = f0;  assign o_sof[1] = f1;  assign o_sof[2] = f2;
  assign o_eol[0] = l0;  assign o_eol[1] = l1;  assign o_eol[2] = l2;
  assign o_err[0] = p0;  assign o_err[1] = p1;  assign o_err[2] = p2;
  assign o_act[0] = a0;  assign o_act[1] = a1;  assign o_act[2] = a2;
  assign o_data[0] = {16'd0, d0};
  assign o_data[1] = {8'd0, d1};
  assign o_data[2] = {24'd0, d2};

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: frames seen since reset, samples collected for the current word, held outputs.
  int          m_edges[3];
  int          m_n[3];
  logic [7:0]  m_s[3][4];
  bit          m_sofp[3];
  bit          m_vsp[3];
  bit          m_dep[3];
  bit          e_vld[3], e_sof[3], e_eol[3], e_err[3], e_act[3];
  logic [31:0] e_data[3];

  logic [31:0] w0[$];
  bit          s0[$];
  logic [31:0] w1[$];
  bit          s1[$];
  int          eolq[$];
  int          v0_cyc, err0_n, err0_cyc;

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_edges[i] = 0; m_n[i] = 0; m_sofp[i] = 1'b1;
        m_vsp[i] = (CP[i] != 0); m_dep[i] = 1'b0;
        e_vld[i] = 0; e_sof[i] = 0; e_eol[i] = 0; e_err[i] = 0; e_act[i] = 0;
        e_data[i] = 32'd0;
      end else begin
        bit fs, le, act;
        logic [31:0] word;
        fs  = (int'(vs) == CP[i]) && (int'(m_vsp[i]) != CP[i]);
        le  = m_dep[i] && !de;
        act = m_edges[i] > CS[i];
        e_vld[i] = 0; e_sof[i] = 0; e_eol[i] = 0; e_err[i] = 0;
        if (act) begin
          if (de) begin
            m_s[i][m_n[i]] = pd;
            m_n[i]++;
            if (m_n[i] == CB[i]) begin
              word = 32'd0;
              for (int k = 0; k < CB[i]; k++) begin
                if (CO[i] == 0) word = word | (32'(m_s[i][k]) << (8 * (CB[i] - 1 - k)));
                else            word = word | (32'(m_s[i][k]) << (8 * k));
              end
              e_data[i] = word;
              e_vld[i]  = 1'b1;
              e_sof[i]  = m_sofp[i];
              m_sofp[i] = 1'b0;
              m_n[i]    = 0;
            end
          end else if (le) begin
            e_eol[i] = 1'b1;
            e_err[i] = (m_n[i] != 0) && !fs;
            m_n[i]   = 0;
          end
          if (fs) m_n[i] = 0;
        end
        if (fs) begin
          m_sofp[i] = 1'b1;
          if (m_edges[i] < 1000) m_edges[i]++;
        end
        e_act[i] = m_edges[i] > CS[i];
        m_vsp[i] = vs;
        m_dep[i] = de;
      end
    end
  endtask

  task automatic cmp(input int i, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL u%0d_%s cyc=%0d got=%0h expected=%0h", i, nm, cyc, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      cmp(i, "vld",  32'(o_vld[i]), 32'(e_vld[i]));
      cmp(i, "data", o_data[i],     e_data[i]);
      cmp(i, "sof",  32'(o_sof[i]), 32'(e_sof[i]));
      cmp(i, "eol",  32'(o_eol[i]), 32'(e_eol[i]));
      cmp(i, "err",  32'(o_err[i]), 32'(e_err[i]));
      cmp(i, "act",  32'(o_act[i]), 32'(e_act[i]));
    end
    if (o_vld[0] === 1'b1) begin w0.push_back(o_data[0]); s0.push_back(o_sof[0]); v0_cyc = cyc; end
    if (o_vld[1] === 1'b1) begin w1.push_back(o_data[1]); s1.push_back(o_sof[1]); end
    if (o_eol[0] === 1'b1) eolq.push_back(cyc);
    if (o_err[0] === 1'b1) begin err0_n++; err0_cyc = cyc; end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    compare_all();
    cyc++;
  endtask

  task automatic drive(input logic v, input logic d, input logic [7:0] p);
    vs = v; de = d; pd = p;
    tick();
  endtask

  task automatic send_line(input int n, input logic [31:0] bytes_msb_first);
    for (int k = 0; k < n; k++) drive(vs, 1'b1, bytes_msb_first[8*(n-1-k) +: 8]);
    for (int k = 0; k < 3; k++) drive(vs, 1'b0, 8'd0);
  endtask

  task automatic frame_pulse();
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic clear_logs();
    w0.delete(); s0.delete(); w1.delete(); s1.delete(); eolq.delete();
    err0_n = 0; err0_cyc = -1; v0_cyc = -1;
  endtask

  initial begin
    logic vs_n, de_n;
    rst = 1'b1; vs = 1'b0; de = 1'b0; pd = 8'd0;
    clear_logs();
    repeat (3) tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0);

    chk("reset_valid",  32'(v0), 32'd0);
    chk("reset_data",   32'(d0), 32'd0);
    chk("reset_active", 32'(a0), 32'd0);

    // Frame A: u0 goes active immediately, first line 12 34 56 78.
    frame_pulse();
    send_line(4, 32'h12345678);
    chk("basic_count", w0.size(), 2);
    if (w0.size() == 2) begin
      chk("basic_word0", w0[0], 32'h1234);
      chk("basic_sof0",  32'(s0[0]), 32'd1);
      chk("basic_word1", w0[1], 32'h5678);
      chk("basic_sof1",  32'(s0[1]), 32'd0);
    end
    chk("basic_eol_after_strobe", (eolq.size() > 0) ? eolq[0] : -1, v0_cyc + 1);
    chk("skip_no_strobe_u1", w1.size(), 0);

    // Partial line, then a clean line that must restart in slot 0.
    clear_logs();
    send_line(3, 32'h00AABBCC);
    send_line(2, 32'h00001122);
    chk("partial_count", w0.size(), 2);
    if (w0.size() == 2) begin
      chk("partial_word", w0[0], 32'hAABB);
      chk("partial_next_line", w0[1], 32'h1122);
    end
    chk("partial_err_count", err0_n, 1);
    chk("partial_err_with_eol", err0_cyc, (eolq.size() > 0) ? eolq[0] : -2);

    // Frames B and C: u1 skips B and goes active on the third frame edge.
    frame_pulse();
    chk("skip_inactive_u1", 32'(a1), 32'd0);
    send_line(3, 32'h00010203);
    chk("skip_frame2_no_strobe", w1.size(), 0);
    frame_pulse();
    chk("skip_active_u1", 32'(a1), 32'd1);
    send_line(3, 32'h00010203);
    chk("b3_count", w1.size(), 1);
    if (w1.size() == 1) begin
      chk("b3_word", w1[0], 32'h030201);
      chk("b3_sof",  32'(s1[0]), 32'd1);
    end

    // Frame edge coinciding with the end of a one-sample line.
    clear_logs();
    drive(1'b0, 1'b1, 8'h5A);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    send_line(2, 32'h0000C1C2);
    chk("midvs_no_err", err0_n, 0);
    chk("midvs_count", w0.size(), 1);
    if (w0.size() == 1) begin
      chk("midvs_word", w0[0], 32'hC1C2);
      chk("midvs_sof",  32'(s0[0]), 32'd1);
    end

    // Reset in the middle of a line.
    clear_logs();
    drive(1'b0, 1'b1, 8'hD1);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'hD2);
    rst = 1'b0;
    chk("rst_valid",  32'(v0), 32'd0);
    chk("rst_data",   32'(d0), 32'd0);
    chk("rst_active", 32'(a0), 32'd0);
    chk("rst_eol",    32'(l0), 32'd0);
    send_line(4, 32'hD3D4D5D6);
    chk("rst_no_strobe", w0.size(), 0);
    frame_pulse();
    send_line(2, 32'h0000E1E2);
    chk("rst_restart_count", w0.size(), 1);
    if (w0.size() == 1) begin
      chk("rst_restart_word", w0[0], 32'hE1E2);
      chk("rst_restart_sof",  32'(s0[0]), 32'd1);
    end

    // Randomized traffic with occasional resets.
    vs_n = vs; de_n = de;
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 39) == 0) vs_n = !vs_n;
      if ($urandom_range(0, 5) == 0)  de_n = !de_n;
      rst = ($urandom_range(0, 699) == 0);
      drive(vs_n, de_n, 8'($urandom));
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
